// File: rtl/line_mem_responder_if.sv
// Cache-line request/response bus plus the burst memory port of line_mem_responder.
// master = cache controller and memory model side, slave = the responder.
interface line_mem_responder_if #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_read;
  logic                   req_write;
  logic [31:0]            req_address;
  logic [LINE_BITS/8-1:0] req_byte_enable;
  logic [LINE_BITS-1:0]   req_wdata;
  logic                   resp_done;
  logic [LINE_BITS-1:0]   resp_rdata;
  logic                   pmem_read;
  logic                   pmem_write;
  logic [31:0]            pmem_address;
  logic [BEAT_BITS-1:0]   pmem_wdata;
  logic [BEAT_BITS-1:0]   pmem_rdata;
  logic                   pmem_resp;

  modport master (
    output req_valid, req_read, req_write, req_address, req_byte_enable, req_wdata,
    output pmem_rdata, pmem_resp,
    input  req_ready, resp_done, resp_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  req_valid, req_read, req_write, req_address, req_byte_enable, req_wdata,
    input  pmem_rdata, pmem_resp,
    output req_ready, resp_done, resp_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/line_mem_responder.sv
// Converts one cache-line request at a time into BEATS-beat memory bursts.
// Define LINE_MEM_RMW_EN to build the read-merge-write path for partial writes.
module line_mem_responder #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  line_mem_responder_if.slave bus
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int BYTES = LINE_BITS / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] buf_q, buf_d;
  logic [BEAT_BITS-1:0] pmem_wdata_q, pmem_wdata_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_done_q, resp_done_d;
  logic                 pmem_read_q, pmem_read_d;
  logic                 pmem_write_q, pmem_write_d;

`ifdef LINE_MEM_RMW_EN
  logic                 merge_q, merge_d;
  logic [BYTES-1:0]     be_q, be_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;

  // Overlay enabled bytes of new_line onto the line read back from memory.
  function automatic logic [LINE_BITS-1:0] merge_line(
    input logic [LINE_BITS-1:0] mem_line,
    input logic [LINE_BITS-1:0] new_line,
    input logic [BYTES-1:0]     be
  );
    logic [LINE_BITS-1:0] m;
    m = mem_line;
    for (int i = 0; i < BYTES; i++) begin
      m[8*i +: 8] = be[i] ? new_line[8*i +: 8] : mem_line[8*i +: 8];
    end
    return m;
  endfunction
`endif

  // Next-state, beat counter, line buffer and next output values.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    pmem_wdata_d = pmem_wdata_q;
`ifdef LINE_MEM_RMW_EN
    merge_d      = merge_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid && (bus.req_read || bus.req_write)) begin
          addr_d = {bus.req_address[31:OFF], {OFF{1'b0}}};
          beat_d = '0;
          // A request with both read and write set is treated as a write.
          if (bus.req_write) begin
            if (bus.req_byte_enable == '0) begin
              state_d = DONE;
            end else begin
`ifdef LINE_MEM_RMW_EN
              be_d    = bus.req_byte_enable;
              wdata_d = bus.req_wdata;
              if (&bus.req_byte_enable) begin
                state_d = WR_BURST;
                buf_d   = bus.req_wdata;
                merge_d = 1'b0;
              end else begin
                state_d = RD_BURST;
                merge_d = 1'b1;
              end
`else
              state_d = WR_BURST;
              buf_d   = bus.req_wdata;
`endif
            end
          end else begin
            state_d = RD_BURST;
`ifdef LINE_MEM_RMW_EN
            merge_d = 1'b0;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end

      RD_BURST: begin
        if (bus.pmem_resp) begin
          buf_d[int'(beat_q)*BEAT_BITS +: BEAT_BITS] = bus.pmem_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
`ifdef LINE_MEM_RMW_EN
            if (merge_q) begin
              buf_d   = merge_line(buf_d, wdata_q, be_q);
              merge_d = 1'b0;
              state_d = WR_BURST;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          state_d = RD_BURST;
        end
      end

      WR_BURST: begin
        if (bus.pmem_resp) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          state_d = WR_BURST;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    if (state_d == WR_BURST) begin
      pmem_wdata_d = buf_d[int'(beat_d)*BEAT_BITS +: BEAT_BITS];
    end else begin
      pmem_wdata_d = pmem_wdata_q;
    end
    req_ready_d  = (state_d == IDLE);
    resp_done_d  = (state_d == DONE);
    pmem_read_d  = (state_d == RD_BURST);
    pmem_write_d = (state_d == WR_BURST);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      addr_q       <= 32'h0000_0000;
      buf_q        <= '0;
      pmem_wdata_q <= '0;
      req_ready_q  <= 1'b1;
      resp_done_q  <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
`ifdef LINE_MEM_RMW_EN
      merge_q      <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      buf_q        <= buf_d;
      pmem_wdata_q <= pmem_wdata_d;
      req_ready_q  <= req_ready_d;
      resp_done_q  <= resp_done_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
`ifdef LINE_MEM_RMW_EN
      merge_q      <= merge_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
`endif
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_done    = resp_done_q;
  assign bus.resp_rdata   = buf_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder with a stallable burst memory model.
// Expectations follow LINE_MEM_RMW_EN the same way the RTL does.
module tb_line_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_mem_responder_if #(.LINE_BITS(256), .BEAT_BITS(64)) bus ();

  line_mem_responder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // memory model state (written only by the model process)
  logic [63:0] mem [0:1023];
  logic [63:0] wr_log [0:3];
  int stall_cyc = 0;
  bit inject = 1'b0;
  int wait_cnt = 0, mbeat = 0, idx = 0;
  int rd_beats = 0, wr_beats = 0, rd_high = 0, overlap = 0, addr_chg = 0, done_cnt = 0;
  logic [31:0] burst_addr = 32'h0;
  bit in_burst = 1'b0;

  // snapshots taken by the stimulus process
  int s_rd, s_wr, s_high, s_chg, s_done;

  localparam logic [63:0] BA = 64'hA0A1_A2A3_A4A5_A6A7;
  localparam logic [63:0] BB = 64'hB0B1_B2B3_B4B5_B6B7;
  localparam logic [63:0] BC = 64'hC0C1_C2C3_C4C5_C6C7;
  localparam logic [63:0] BD = 64'hD0D1_D2D3_D4D5_D6D7;
  localparam logic [63:0] ALL_F = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Burst memory: answers one beat after stall_cyc waiting cycles, checks bus rules.
  always @(negedge clk) begin
    bus.pmem_resp = 1'b0;
    if (bus.resp_done === 1'b1) done_cnt++;
    if (bus.pmem_read === 1'b1 && bus.pmem_write === 1'b1) overlap++;
    if (!rst_n) begin
      wait_cnt = 0; mbeat = 0; in_burst = 1'b0;
    end else if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
      if (!in_burst) begin
        in_burst = 1'b1;
        burst_addr = bus.pmem_address;
      end else if (bus.pmem_address !== burst_addr) begin
        addr_chg++;
      end
      if (bus.pmem_read === 1'b1) rd_high++;
      if (wait_cnt >= stall_cyc) begin
        wait_cnt = 0;
        bus.pmem_resp = 1'b1;
        idx = (int'(bus.pmem_address[12:3]) + mbeat) % 1024;
        if (bus.pmem_read === 1'b1) begin
          bus.pmem_rdata = mem[idx];
          rd_beats++;
        end else begin
          mem[idx] = bus.pmem_wdata;
          wr_log[mbeat] = bus.pmem_wdata;
          wr_beats++;
        end
        mbeat = (mbeat + 1) % 4;
      end else begin
        wait_cnt++;
      end
    end else begin
      in_burst = 1'b0; wait_cnt = 0; mbeat = 0;
      if (inject) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  task automatic snap();
    s_rd = rd_beats; s_wr = wr_beats; s_high = rd_high; s_chg = addr_chg; s_done = done_cnt;
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] be, input logic [255:0] wd,
                        output int lat, output logic [255:0] line);
    snap();
    bus.req_valid = 1'b1; bus.req_read = rd; bus.req_write = wr;
    bus.req_address = addr; bus.req_byte_enable = be; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
    lat = 0;
    while (bus.resp_done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    line = bus.resp_rdata;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  function automatic logic [255:0] byte_line(input logic [7:0] base);
    logic [255:0] l;
    for (int i = 0; i < 32; i++) l[8*i +: 8] = base + 8'(i);
    return l;
  endfunction

  int lat;
  logic [255:0] line;
  logic [255:0] exp_rd;
  logic [255:0] hold;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = ALL_F;
    mem[32'h1220 >> 3] = BA; mem[(32'h1220 >> 3) + 1] = BB;
    mem[(32'h1220 >> 3) + 2] = BC; mem[(32'h1220 >> 3) + 3] = BD;
    exp_rd = {BD, BC, BB, BA};
    bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
    bus.req_address = 32'h0; bus.req_byte_enable = 32'h0; bus.req_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = 64'h0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_ready", bus.req_ready, 1'b1);
    chk_eq("rst_done", bus.resp_done, 1'b0);
    chk_eq("rst_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk_eq("rst_addr", bus.pmem_address, 32'h0);
    chk_eq("rst_wdata", bus.pmem_wdata, 64'h0);
    chk_eq("rst_rdata", bus.resp_rdata, 256'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // line read, single-cycle memory
    do_req(1'b1, 1'b0, 32'h0000_1234, 32'h0, '0, lat, line);
    chk_eq("rd_addr", burst_addr, 32'h0000_1220);
    chk_eq("rd_line", line, exp_rd);
    chk_eq("rd_lat", lat, 4);
    chk_eq("rd_done_cnt", done_cnt - s_done, 1);
    chk_eq("rd_beats", rd_beats - s_rd, 4);
    chk_eq("rd_no_wr", wr_beats - s_wr, 0);

    // full write
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, byte_line(8'h00), lat, line);
    chk_eq("fw_beat0", wr_log[0], 64'h0706_0504_0302_0100);
    chk_eq("fw_beat3", wr_log[3], 64'h1F1E_1D1C_1B1A_1918);
    chk_eq("fw_beats", wr_beats - s_wr, 4);
    chk_eq("fw_no_rd", rd_beats - s_rd, 0);
    chk_eq("fw_done_cnt", done_cnt - s_done, 1);
    chk_eq("fw_line", line, byte_line(8'h00));
    chk_eq("fw_mem1", mem[9], 64'h0F0E_0D0C_0B0A_0908);

    // partial write onto an all-ones line
    do_req(1'b0, 1'b1, 32'h0000_0080, 32'h0000_000F, byte_line(8'h00), lat, line);
`ifdef LINE_MEM_RMW_EN
    chk_eq("pw_beat0", wr_log[0], 64'hFFFF_FFFF_0302_0100);
    chk_eq("pw_beat1", wr_log[1], ALL_F);
    chk_eq("pw_beat3", wr_log[3], ALL_F);
    chk_eq("pw_rd_beats", rd_beats - s_rd, 4);
    chk_eq("pw_lat", lat, 8);
`else
    chk_eq("pw_beat0", wr_log[0], 64'h0706_0504_0302_0100);
    chk_eq("pw_beat3", wr_log[3], 64'h1F1E_1D1C_1B1A_1918);
    chk_eq("pw_rd_beats", rd_beats - s_rd, 0);
    chk_eq("pw_lat", lat, 4);
`endif
    chk_eq("pw_wr_beats", wr_beats - s_wr, 4);
    chk_eq("pw_done_cnt", done_cnt - s_done, 1);

    // stalled memory: 5 idle cycles before every beat
    stall_cyc = 5;
    do_req(1'b1, 1'b0, 32'h0000_1220, 32'h0, '0, lat, line);
    chk_eq("st_line", line, exp_rd);
    chk_eq("st_lat", lat, 24);
    chk_eq("st_rd_high", rd_high - s_high, 24);
    chk_eq("st_beats", rd_beats - s_rd, 4);
    chk_eq("st_addr_chg", addr_chg - s_chg, 0);
    chk_eq("st_done_cnt", done_cnt - s_done, 1);
    stall_cyc = 0;

    // zero byte-enable write, then read+write both set
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0, byte_line(8'h40), lat, line);
    chk_eq("be0_lat", lat, 0);
    chk_eq("be0_beats", (rd_beats - s_rd) + (wr_beats - s_wr), 0);
    chk_eq("be0_done_cnt", done_cnt - s_done, 1);
    do_req(1'b1, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, byte_line(8'h20), lat, line);
    chk_eq("rw_no_rd", rd_beats - s_rd, 0);
    chk_eq("rw_wr_beats", wr_beats - s_wr, 4);
    chk_eq("rw_beat0", wr_log[0], 64'h2726_2524_2322_2120);

    // stray pmem_resp while idle must be ignored
    hold = bus.resp_rdata;
    snap();
    inject = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    inject = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk_eq("spur_ready", bus.req_ready, 1'b1);
    chk_eq("spur_done", done_cnt - s_done, 0);
    chk_eq("spur_rdata", bus.resp_rdata, hold);

    // reset in the middle of a read burst, at beat 2
    stall_cyc = 3;
    snap();
    bus.req_valid = 1'b1; bus.req_read = 1'b1; bus.req_address = 32'h0000_1220;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_read = 1'b0;
    lat = 0;
    while (mbeat != 2 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_eq("mid_reached_beat2", mbeat, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_eq("mid_rst_read", bus.pmem_read, 1'b0);
    chk_eq("mid_rst_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk_eq("mid_rst_no_done", done_cnt - s_done, 0);
    chk_eq("mid_rst_idle_read", bus.pmem_read, 1'b0);
    stall_cyc = 0;
    do_req(1'b1, 1'b0, 32'h0000_1234, 32'h0, '0, lat, line);
    chk_eq("post_rst_line", line, exp_rd);
    chk_eq("post_rst_lat", lat, 4);
    chk_eq("post_rst_done_cnt", done_cnt - s_done, 1);

    chk_eq("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
